cordic_frame_sched: RTL and testbench

- Sequencer that time-shares one iterative CORDIC core among N_CH phase-tracking channels.
- Triggered by the periodic frame pulse from the CORDIC init-timing generator (1 MHz clock, 200-cycle high / 200-cycle low).
- On each frame-pulse rising edge it snapshots all channel operands, feeds them to the CORDIC one at a time, and returns tagged phase/magnitude results.
- Also flags core timeouts and frame overruns.

---
 rtl/cordic_frame_sched.sv | 132 +++++++++++++
 tb/tb_cordic_frame_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_frame_sched.sv
// cordic_frame_sched: shares one iterative CORDIC core across N_CH channels.
// A rising edge of frame_pulse snapshots every channel's operands. The
// channels are then issued to the core one at a time. Each completion is
// returned as a tagged result. Core timeouts and frame overruns are flagged
// sticky until reset.
module cordic_frame_sched #(
  parameter  int N_CH    = 4,
  parameter  int DW      = 16,
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_pulse,
  input  logic [N_CH*DW-1:0]   ch_x,
  input  logic [N_CH*DW-1:0]   ch_y,
  output logic                 cordic_start,
  output logic [DW-1:0]        cordic_x,
  output logic [DW-1:0]        cordic_y,
  input  logic                 cordic_done,
  input  logic [DW-1:0]        cordic_phase,
  input  logic [DW-1:0]        cordic_mag,
  output logic                 res_valid,
  output logic [CW-1:0]        res_ch,
  output logic [DW-1:0]        res_phase,
  output logic [DW-1:0]        res_mag,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 overrun
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                   state;
  logic                     fp_q;
  logic                     adv;      // result cycle; next channel issues after it
  logic [CW-1:0]            ch_idx;
  logic [TW-1:0]            cnt;
  logic [N_CH-1:0][DW-1:0]  snap_x;
  logic [N_CH-1:0][DW-1:0]  snap_y;
  logic                     rise;

  assign rise = frame_pulse & ~fp_q;

  // Frame sequencer: snapshot, issue each channel, collect result or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fp_q         <= 1'b0;
      adv          <= 1'b0;
      ch_idx       <= '0;
      cnt          <= '0;
      snap_x       <= '0;
      snap_y       <= '0;
      cordic_start <= 1'b0;
      cordic_x     <= '0;
      cordic_y     <= '0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_phase    <= '0;
      res_mag      <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      fp_q         <= frame_pulse;
      cordic_start <= 1'b0;
      res_valid    <= 1'b0;
      frame_done   <= 1'b0;
      // busy is still high in the frame_done cycle, so a rise there is an overrun
      if (rise && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (rise && !busy) begin
            snap_x       <= ch_x;
            snap_y       <= ch_y;
            ch_idx       <= '0;
            busy         <= 1'b1;
            // channel 0 issues straight from the live inputs (same as snapshot)
            cordic_start <= 1'b1;
            cordic_x     <= ch_x[DW-1:0];
            cordic_y     <= ch_y[DW-1:0];
            cnt          <= '0;
            state        <= START;
          end
        end
        START: begin
          // counter was cleared on entry, so the start cycle counts as cycle 0
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (adv) begin
            adv          <= 1'b0;
            cordic_start <= 1'b1;
            cordic_x     <= snap_x[ch_idx];
            cordic_y     <= snap_y[ch_idx];
            cnt          <= '0;
            state        <= START;
          end else if (cordic_done || cnt == CNT_MAX) begin
            // done wins over a coincident timeout
            if (cordic_done) begin
              res_valid <= 1'b1;
              res_ch    <= ch_idx;
              res_phase <= cordic_phase;
              res_mag   <= cordic_mag;
            end else begin
              err_timeout <= 1'b1;
            end
            if (ch_idx == LAST_CH) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              adv    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_frame_sched.sv
// Self-checking bench for cordic_frame_sched: a behavioural CORDIC core model
// answers each start after a programmable latency. A negedge monitor logs
// starts, results, frame_done and timeout events. The directed sequence
// compares them against expectations derived from the random snapshot operands.
`timescale 1ns/1ps
module tb_cordic_frame_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk, rst, frame_pulse;
  logic [N*W-1:0] ch_x, ch_y;
  logic           cordic_start, cordic_done;
  logic [W-1:0]   cordic_x, cordic_y, cordic_phase, cordic_mag;
  logic           res_valid, frame_done, busy, err_timeout, overrun;
  logic [1:0]     res_ch;
  logic [W-1:0]   res_phase, res_mag;

  cordic_frame_sched #(.N_CH(N), .DW(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .ch_x(ch_x), .ch_y(ch_y),
    .cordic_start(cordic_start), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_done(cordic_done), .cordic_phase(cordic_phase), .cordic_mag(cordic_mag),
    .res_valid(res_valid), .res_ch(res_ch), .res_phase(res_phase), .res_mag(res_mag),
    .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  typedef struct {int cyc; int ch; logic [W-1:0] a; logic [W-1:0] b;} rec_t;
  rec_t sq[$];   // starts: cycle, operands
  rec_t rq[$];   // results: cycle, channel, phase, mag
  int   fdq[$];  // frame_done cycles
  int   erq[$];  // err_timeout rising cycles

  int cyc = 0;
  int lat, drop, sbase, rbase, fbase, ebase, rc;
  bit spur;
  int tests = 0, fails = 0;
  logic [W-1:0] ex [N];
  logic [W-1:0] ey [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus core model (core: phase = x + 0x1000, mag = y ^ 0x2000).
  int tmr; bit pend; bit perr = 1'b0;
  logic [W-1:0] px, py;
  always @(negedge clk) begin
    if (cordic_start) sq.push_back('{cyc, 0, cordic_x, cordic_y});
    if (res_valid) rq.push_back('{cyc, int'(res_ch), res_phase, res_mag});
    if (frame_done) fdq.push_back(cyc);
    if (err_timeout && !perr) erq.push_back(cyc);
    perr = err_timeout;
    cordic_done = 1'b0;
    if (!rst) pend = 1'b0;
    else if (cordic_start) begin
      pend = (int'(sq.size()) - 1 - sbase) != drop;
      tmr = 0; px = cordic_x; py = cordic_y;
    end else if (pend) begin
      tmr++;
      if (tmr == lat) begin
        cordic_done = 1'b1; cordic_phase = px + 16'h1000; cordic_mag = py ^ 16'h2000;
        pend = 1'b0;
      end
    end
    if (spur) begin cordic_done = 1'b1; cordic_phase = 16'hdead; cordic_mag = 16'hbeef; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, 32'({cordic_start, res_valid, frame_done, busy, err_timeout, overrun}), 0);
    chk({tag, ".cx"}, 32'(cordic_x), 0);
    chk({tag, ".cy"}, 32'(cordic_y), 0);
    chk({tag, ".res"}, 32'({res_ch, res_phase ^ res_mag, res_phase | res_mag}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic mark(input int l, input int d);
    lat = l; drop = d;
    sbase = sq.size(); rbase = rq.size(); fbase = fdq.size(); ebase = erq.size();
    for (int i = 0; i < N; i++) begin ex[i] = 16'($urandom); ey[i] = 16'($urandom); end
    ch_x = {ex[3], ex[2], ex[1], ex[0]};
    ch_y = {ey[3], ey[2], ey[1], ey[0]};
  endtask

  // One 400-cycle frame period; optional operand change and mid-frame re-rise.
  task automatic run_frame(input int l, input int d, input bit chg, input bit dbl);
    mark(l, d);
    @(negedge clk); frame_pulse = 1'b1; rc = cyc;
    @(negedge clk);
    if (chg) begin ch_x = {N{16'h7fff}}; ch_y = {N{16'h8000}}; end
    for (int k = 0; k < 198; k++) begin
      @(negedge clk);
      if (dbl && k == 8) frame_pulse = 1'b0;
      if (dbl && k == 9) frame_pulse = 1'b1;
    end
    frame_pulse = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int ns, nr, nexp, k;
    ns = sq.size() - sbase;
    nr = rq.size() - rbase;
    nexp = (drop < 0) ? N : N - 1;
    chk({tag, ".starts"}, 32'(ns), N);
    if (ns == N) begin
      chk({tag, ".start_lat"}, 32'(sq[sbase].cyc), 32'(rc + 1));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s.x%0d", tag, i), 32'(sq[sbase+i].a), 32'(ex[i]));
        chk($sformatf("%s.y%0d", tag, i), 32'(sq[sbase+i].b), 32'(ey[i]));
      end
      for (int i = 1; i < N; i++)
        chk($sformatf("%s.gap%0d", tag, i), 32'(sq[sbase+i].cyc - sq[sbase+i-1].cyc),
            32'((drop == i - 1) ? 65 : lat + 2));
    end
    chk({tag, ".nres"}, 32'(nr), 32'(nexp));
    if (nr == nexp && ns == N) begin
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (i != drop) begin
          chk($sformatf("%s.ch%0d", tag, k), 32'(rq[rbase+k].ch), 32'(i));
          chk($sformatf("%s.ph%0d", tag, k), 32'(rq[rbase+k].a), 32'(16'(ex[i] + 16'h1000)));
          chk($sformatf("%s.mag%0d", tag, k), 32'(rq[rbase+k].b), 32'(ey[i] ^ 16'h2000));
          chk($sformatf("%s.rlat%0d", tag, k), 32'(rq[rbase+k].cyc), 32'(sq[sbase+i].cyc + lat + 1));
          k++;
        end
      end
    end
    chk({tag, ".nfd"}, 32'(fdq.size() - fbase), 1);
    if (fdq.size() - fbase == 1 && nr == nexp && nr > 0 && drop != N - 1)
      chk({tag, ".fd_cyc"}, 32'(fdq[fbase]), 32'(rq[rq.size()-1].cyc));
    chk({tag, ".busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; frame_pulse = 1'b0; spur = 1'b0; lat = 18; drop = -1;
    sbase = 0; ch_x = '1; ch_y = '1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Normal frame with operands scrambled right after acceptance.
    run_frame(18, -1, 1'b1, 1'b0);
    check_frame("A");
    chk("A.err", 32'(err_timeout), 0);
    chk("A.ovr", 32'(overrun), 0);

    // Channel 2 never completes.
    run_frame(18, 2, 1'b0, 1'b0);
    check_frame("B");
    chk("B.err", 32'(err_timeout), 1);
    chk("B.nerr", 32'(erq.size() - ebase), 1);
    if (erq.size() - ebase == 1 && sq.size() - sbase == N)
      chk("B.err_cyc", 32'(erq[ebase]), 32'(sq[sbase+2].cyc + 64));
    do_reset();
    chk("B.err_clr", 32'(err_timeout), 0);

    // Second rising edge ~11 cycles into the frame.
    run_frame(18, -1, 1'b0, 1'b1);
    check_frame("C");
    chk("C.ovr", 32'(overrun), 1);
    chk("C.err", 32'(err_timeout), 0);
    do_reset();

    // Done lands on the last allowed cycle, then a spurious done in IDLE.
    run_frame(63, -1, 1'b0, 1'b0);
    check_frame("D");
    chk("D.err", 32'(err_timeout), 0);
    n = rq.size();
    @(negedge clk); #1 spur = 1'b1;
    @(negedge clk); #1 spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("D.spur_res", 32'(rq.size()), 32'(n));
    chk("D.spur_busy", 32'(busy), 0);

    // Reset while waiting on channel 1.
    mark(18, -1);
    @(negedge clk); frame_pulse = 1'b1;
    n = 0;
    while (sq.size() - sbase < 2 && n < 200) begin @(negedge clk); n++; end
    chk("E.reach_ch1", 32'(sq.size() - sbase), 2);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("E.async");
    repeat (2) @(negedge clk);
    frame_pulse = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = sq.size();
    repeat (5) @(negedge clk);
    chk("E.no_restart", 32'(sq.size()), 32'(n));
    run_frame(18, -1, 1'b0, 1'b0);
    check_frame("E");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
